requantize_exp_fetch: RTL
=========================

// Module: requantize_exp_fetch
// PURPOSE
//  Read-side sequencer for the 9-bit-addressed, 32-bit requantize exponent ROM (1-cycle registered read).
//  Accepts a valid/ready stream of exponents from the requantizer, issues ROM reads and absorbs the ROM latency.
//  Buffers results in a small FIFO and returns them in order on a valid/ready output stream.
//  Sustains 1 lookup/cycle under no backpressure; never drops or duplicates a lookup under backpressure.
// PARAMETERS
//  FIFO_DEPTH  3  result buffer entries (min 2); 3 gives full throughput with no out_ready->exp_ready path
//  DATA_W      32 ROM word width
//  ADDR_W      9  ROM address width (exponent width)
// PORTS
//  clk        in   1       system clock, all logic rising-edge
//  reset      in   1       synchronous, active-high reset
//  exp_valid  in   1       exponent request valid
//  exp_ready  out  1       request accepted when exp_valid && exp_ready
//  exponent   in   ADDR_W  ROM address for this request
//  exp_last   in   1       marks final request of a granule; carried to out_last
//  rom_en     out  1       ROM read enable (to romfile read_en)
//  rom_addr   out  ADDR_W  ROM read address (to romfile read_addr)
//  rom_data   in   DATA_W  ROM output, valid 1 cycle after rom_en
//  out_valid  out  1       result valid
//  out_ready  in   1       result consumed when out_valid && out_ready
//  out_data   out  DATA_W  ROM word for oldest outstanding request
//  out_last   out  1       exp_last of that request
//  busy       out  1       inflight || occupancy != 0
// BEHAVIOUR
//  - Reset: inflight=0, last_q=0, occupancy=0, rd/wr ptrs=0; out_valid=0, out_data=0, out_last=0, busy=0, rom_en=0.
//  - exp_ready = !reset && (occupancy + inflight) < FIFO_DEPTH; registered state only, no dependence on out_ready.
//  - accept = exp_valid && exp_ready; rom_en = accept; rom_addr = exponent (combinational pass-through).
//  - Cycle N accept -> inflight<=1, last_q<=exp_last at N+1; at end of N+1 {last_q, rom_data} written to FIFO.
//  - First accept at cycle N gives out_valid=1 at N+2 (2-cycle latency request->result).
//  - inflight <= accept every cycle (back-to-back accepts keep inflight=1; one result written per cycle).
//  - out_valid = occupancy != 0; out_data/out_last = FIFO head; when empty drive 0.
//  - pop = out_valid && out_ready; push = inflight. Simultaneous push+pop: occupancy unchanged, both ptrs advance.
//  - Pointers wrap modulo FIFO_DEPTH (non-power-of-2 depth supported: explicit wrap at FIFO_DEPTH-1).
//  - Overflow impossible by construction (credit covers inflight); push into full FIFO is an assertion failure.
//  - Pop on empty ignored (out_valid=0). exp_valid while !exp_ready: request held by producer, no ROM read.
//  - Ordering: results leave in exact request order; out_last aligned with its own data word.
//  - Reset mid-operation: pending ROM response discarded (inflight cleared), FIFO emptied, out_valid=0 next cycle.
//  - exponent/exp_last sampled only on accept; values while exp_valid=0 ignored.
//  - Exponent range: full 0..2^ADDR_W-1 passed unchanged; no clamping.
// TESTING
//  ROM model: 1-cycle registered, data = 32'hA000_0000 | addr.
//  T1 single: exponent=9'd5, last=1, out_ready=1 -> out_valid at +2 cycles, out_data=32'hA000_0005, out_last=1, busy=0 after.
//  T2 stream: exponents 0..15 back-to-back, out_ready=1 -> exp_ready stays 1, 16 outputs on 16 consecutive cycles, in order.
//  T3 backpressure: out_ready=0, send 9'h1FF,9'h100,9'h001,9'h0AA -> exactly 3 accepted, exp_ready=0, occupancy=3;
//      raise out_ready -> A00001FF, A0000100, A0000001, then 4th accepted and A00000AA out.
//  T4 random out_ready (50%) + random exp_valid, 1000 requests -> scoreboard match, no loss/dup, pointer wrap exercised.
//  T5 reset with inflight=1 and occupancy=2 -> next cycle out_valid=0, busy=0, exp_ready=1; stale word never appears.
//  T6 last flags: granules of 3 with last on 3rd, under backpressure -> out_last high on every 3rd output only.

Source files
------------

// File: rtl/requantize_exp_fetch.sv
// requantize_exp_fetch
// Read-side sequencer for the requantize exponent ROM. Requests are accepted
// on a valid/ready stream, turned into 1-cycle registered ROM reads, and the
// returned words are parked in a small in-order FIFO until the consumer takes
// them on a valid/ready output stream.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid && ready are both high; a producer holding valid keeps its
// payload stable until that edge; ready never depends on the partner's valid.
//
// Credit scheme: a slot is reserved the moment a request is accepted, so the
// FIFO occupancy plus the one possible ROM read in flight can never exceed
// FIFO_DEPTH. exp_ready is computed from registered state (and reset) only,
// so there is no combinational out_ready -> exp_ready path.
module requantize_exp_fetch #(
    parameter int FIFO_DEPTH = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [ADDR_W-1:0] exponent,
    input  logic              exp_last,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

    // FIFO entry layout: {last flag, ROM word}
    typedef logic [DATA_W:0] entry_t;

    logic             inflight_q, inflight_d;
    logic             last_q,     last_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];

    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    entry_t           head;

    // Explicit wrap so non-power-of-2 depths cycle correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Request side: credit check, accept, ROM read issue.
    always_comb begin
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        exp_ready   = !reset && (credit_used < CREDIT_MAX);
        accept      = exp_valid && exp_ready;
        rom_en      = accept;
        rom_addr    = exponent;
    end

    // Result side: FIFO head presented, zeros when empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_data  = out_valid ? head[DATA_W-1:0] : '0;
        out_last  = out_valid ? head[DATA_W] : 1'b0;
        busy      = inflight_q || (count_q != '0);
        push      = inflight_q;
        pop       = out_valid && out_ready;
    end

    // Next-state: ROM latency stage and FIFO bookkeeping.
    always_comb begin
        inflight_d = accept;
        last_d     = accept ? exp_last : last_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = {last_q, rom_data};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops any pending ROM response and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            last_q     <= last_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
        end
    end

    // The credit scheme makes a push into a full FIFO unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CNT_FULL) && !pop));

endmodule
